// File: rtl/di_router_pkg.sv
// -----------------------------------------------------------------------------
// di_router_pkg
// Shared definitions for the device-interface terminal router:
//   - di_state_e        : router FSM state encoding
//   - DI_STATUS_*       : transfer status words reported to the host
//   - DI_ABORT_DATA     : read data returned while a transfer is aborted
//   - di_idx_width()    : width of a channel index for a given channel count
// No ports (package).
// -----------------------------------------------------------------------------
package di_router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_ABORT    = 3'd3,
        ST_UNMAPPED = 3'd4
    } di_state_e;

    localparam logic [15:0] DI_STATUS_OK      = 16'h0000;
    localparam logic [15:0] DI_STATUS_UNDEF   = 16'hFFFF;
    localparam logic [15:0] DI_STATUS_TIMEOUT = 16'hFFFE;
    localparam logic [15:0] DI_ABORT_DATA     = 16'hDEAD;
    localparam logic [15:0] DI_IDLE_DATA      = 16'h0000;

    // A single channel still needs a 1-bit index so vectors never collapse to zero width.
    function automatic int di_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/di_term_router_if.sv
// -----------------------------------------------------------------------------
// di_term_router_if
// FX2 device-interface (di_*) bus between the host side and the router.
// Modports:
//   master : host side; drives address/length/data/strobes, receives returns
//   slave  : router side; consumes terminal address and strobes, drives returns
//   term   : terminal blocks; register address, length and write data are
//            broadcast to every terminal straight from the bus
// -----------------------------------------------------------------------------
interface di_term_router_if;

    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic [15:0] di_reg_datai;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    logic        di_write_mode;
    logic        di_write;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy;
    logic        di_write_rdy;
    logic [15:0] di_transfer_status;

    modport master (
        output di_term_addr, di_reg_addr, di_len, di_reg_datai,
        output di_read_mode, di_read_req, di_read, di_write_mode, di_write,
        input  di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status
    );

    modport slave (
        input  di_term_addr,
        input  di_read_mode, di_read_req, di_read, di_write_mode, di_write,
        output di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status
    );

    modport term (
        input  di_term_addr, di_reg_addr, di_len, di_reg_datai
    );

endinterface

// File: rtl/di_addr_decode.sv
// -----------------------------------------------------------------------------
// di_addr_decode
// Combinational priority match of a 16-bit address against a flattened table
// of NUM_TERMS addresses (entry i = TERM_ADDRS[16i+15:16i]). When several
// entries match, the lowest index wins.
// Ports:
//   addr [15:0]     in  : address to decode
//   hit             out : at least one entry matched
//   idx [IDX_W-1:0] out : lowest matching index (0 when no hit)
// -----------------------------------------------------------------------------
module di_addr_decode
    import di_router_pkg::*;
#(
    parameter int                      NUM_TERMS  = 4,
    parameter int                      IDX_W      = 2,
    parameter logic [NUM_TERMS*16-1:0] TERM_ADDRS = {16'h0003, 16'h0002, 16'h0001, 16'h0000}
) (
    input  logic [15:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the highest index down so the lowest match overwrites last.
    always_comb begin
        hit = 1'b0;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_TERMS - 1; i >= 0; i--) begin
            hit = hit | (addr == TERM_ADDRS[16*i +: 16]);
            idx = (addr == TERM_ADDRS[16*i +: 16]) ? i[IDX_W-1:0] : idx;
        end
    end

endmodule

// File: rtl/di_term_router.sv
// -----------------------------------------------------------------------------
// di_term_router
// Routes the FX2 device-interface port to one of NUM_TERMS terminal blocks.
// On a rising read/write mode in IDLE the terminal address is decoded and the
// channel index latched into sel for the whole transfer; strobes are gated to
// that channel only and its returns are muxed back with no added latency.
// Unmapped addresses are answered locally (UNDEF_DATA, status 16'hFFFF).
//
// Optional feature macro: DI_ROUTER_TIMEOUT_EN
//   defined   : per-transfer stall watchdog; after TIMEOUT_CYCLES stalled clocks
//               the transfer is aborted (data 16'hDEAD, status 16'hFFFE) until
//               the active mode falls.
//   undefined : no watchdog, READ/WRITE wait indefinitely.
//
// Ports:
//   ifclk, reset               : interface clock, async active-high reset
//   di (slave modport)         : host-side device-interface bus
//   ch_read_mode/req/read      : gated read strobes, one bit per channel
//   ch_write_mode/write        : gated write strobes, one bit per channel
//   ch_reg_datao, ch_transfer_status : per-channel 16-bit returns (flattened)
//   ch_read_rdy, ch_write_rdy  : per-channel ready flags
//   busy                       : router is not IDLE
// -----------------------------------------------------------------------------
module di_term_router
    import di_router_pkg::*;
#(
    parameter int                      NUM_TERMS      = 4,
    parameter logic [NUM_TERMS*16-1:0] TERM_ADDRS     = {16'h0003, 16'h0002, 16'h0001, 16'h0000},
    parameter int                      TIMEOUT_CYCLES = 4096,
    parameter logic [15:0]             UNDEF_DATA     = 16'hAAAA
) (
    input  logic                      ifclk,
    input  logic                      reset,
    di_term_router_if.slave           di,
    output logic [NUM_TERMS-1:0]      ch_read_mode,
    output logic [NUM_TERMS-1:0]      ch_read_req,
    output logic [NUM_TERMS-1:0]      ch_read,
    output logic [NUM_TERMS-1:0]      ch_write_mode,
    output logic [NUM_TERMS-1:0]      ch_write,
    input  logic [NUM_TERMS*16-1:0]   ch_reg_datao,
    input  logic [NUM_TERMS-1:0]      ch_read_rdy,
    input  logic [NUM_TERMS-1:0]      ch_write_rdy,
    input  logic [NUM_TERMS*16-1:0]   ch_transfer_status,
    output logic                      busy
);

    localparam int SEL_W = di_idx_width(NUM_TERMS);

    di_state_e        state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             is_wr_q, is_wr_d;     // transfer direction, decides which mode ends it
    logic             rd_mode_q, wr_mode_q; // previous mode levels for edge detection

    logic             dec_hit_s;
    logic [SEL_W-1:0] dec_idx_s;
    logic             rd_rise_s, wr_rise_s, active_mode_s, timeout_s;
    logic [15:0]      sel_datao_s, sel_status_s;
    logic             sel_rd_rdy_s, sel_wr_rdy_s;

    di_addr_decode #(
        .NUM_TERMS  (NUM_TERMS),
        .IDX_W      (SEL_W),
        .TERM_ADDRS (TERM_ADDRS)
    ) u_decode (
        .addr (di.di_term_addr),
        .hit  (dec_hit_s),
        .idx  (dec_idx_s)
    );

    // Return mux from the latched channel index.
    always_comb begin
        sel_datao_s  = 16'h0000;
        sel_status_s = 16'h0000;
        sel_rd_rdy_s = 1'b0;
        sel_wr_rdy_s = 1'b0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            sel_datao_s  = (sel_q == i[SEL_W-1:0]) ? ch_reg_datao[16*i +: 16]       : sel_datao_s;
            sel_status_s = (sel_q == i[SEL_W-1:0]) ? ch_transfer_status[16*i +: 16] : sel_status_s;
            sel_rd_rdy_s = (sel_q == i[SEL_W-1:0]) ? ch_read_rdy[i]                 : sel_rd_rdy_s;
            sel_wr_rdy_s = (sel_q == i[SEL_W-1:0]) ? ch_write_rdy[i]                : sel_wr_rdy_s;
        end
    end

`ifdef DI_ROUTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        stall_s;

    // Watchdog: count consecutive cycles with a request pending and the terminal not ready.
    always_comb begin
        case (state_q)
            ST_READ:  stall_s = (di.di_read_req | di.di_read) & ~sel_rd_rdy_s;
            ST_WRITE: stall_s = di.di_write & ~sel_wr_rdy_s;
            default:  stall_s = 1'b0;
        endcase
        if (!stall_s) begin
            cnt_d = 16'h0000;
        end else if (cnt_q == 16'hFFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 16'h0001;
        end
        // Abort on the edge at which the count reaches the limit.
        timeout_s = stall_s & (cnt_d == TIMEOUT_CYCLES[15:0]);
    end

    // Watchdog counter register.
    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [15:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT_CYCLES[15:0];
    assign timeout_s        = 1'b0;
`endif

    assign rd_rise_s     = di.di_read_mode & ~rd_mode_q;
    assign wr_rise_s     = di.di_write_mode & ~wr_mode_q;
    assign active_mode_s = is_wr_q ? di.di_write_mode : di.di_read_mode;

    // Next-state logic; the opposite mode is ignored until the router is back in IDLE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        is_wr_d = is_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_rise_s) begin
                    is_wr_d = 1'b0;
                    sel_d   = dec_hit_s ? dec_idx_s : sel_q;
                    state_d = dec_hit_s ? ST_READ : ST_UNMAPPED;
                end else if (wr_rise_s) begin
                    is_wr_d = 1'b1;
                    sel_d   = dec_hit_s ? dec_idx_s : sel_q;
                    state_d = dec_hit_s ? ST_WRITE : ST_UNMAPPED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (!active_mode_s) begin
                    state_d = ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ABORT, ST_UNMAPPED: begin
                if (!active_mode_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, selected channel and mode-edge registers.
    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= {SEL_W{1'b0}};
            is_wr_q   <= 1'b0;
            rd_mode_q <= 1'b0;
            wr_mode_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            is_wr_q   <= is_wr_d;
            rd_mode_q <= di.di_read_mode;
            wr_mode_q <= di.di_write_mode;
        end
    end

    // Strobe gating and host returns; strobes depend on the registered state so reset clears them at once.
    always_comb begin
        ch_read_mode          = {NUM_TERMS{1'b0}};
        ch_read_req           = {NUM_TERMS{1'b0}};
        ch_read               = {NUM_TERMS{1'b0}};
        ch_write_mode         = {NUM_TERMS{1'b0}};
        ch_write              = {NUM_TERMS{1'b0}};
        di.di_reg_datao       = DI_IDLE_DATA;
        di.di_read_rdy        = 1'b1;
        di.di_write_rdy       = 1'b1;
        di.di_transfer_status = DI_STATUS_OK;
        case (state_q)
            ST_READ: begin
                ch_read_mode[sel_q]   = di.di_read_mode;
                ch_read_req[sel_q]    = di.di_read_req;
                ch_read[sel_q]        = di.di_read;
                di.di_reg_datao       = sel_datao_s;
                di.di_read_rdy        = sel_rd_rdy_s;
                di.di_write_rdy       = sel_wr_rdy_s;
                di.di_transfer_status = sel_status_s;
            end
            ST_WRITE: begin
                ch_write_mode[sel_q]  = di.di_write_mode;
                ch_write[sel_q]       = di.di_write;
                di.di_reg_datao       = sel_datao_s;
                di.di_read_rdy        = sel_rd_rdy_s;
                di.di_write_rdy       = sel_wr_rdy_s;
                di.di_transfer_status = sel_status_s;
            end
            ST_UNMAPPED: begin
                di.di_reg_datao       = UNDEF_DATA;
                di.di_transfer_status = DI_STATUS_UNDEF;
            end
            ST_ABORT: begin
                di.di_reg_datao       = DI_ABORT_DATA;
                di.di_transfer_status = DI_STATUS_TIMEOUT;
            end
            default: begin
                di.di_reg_datao       = DI_IDLE_DATA;
                di.di_transfer_status = DI_STATUS_OK;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_di_term_router.sv
// -----------------------------------------------------------------------------
// tb_di_term_router
// Directed self-checking bench for di_term_router. Channel map:
//   ch0=16'h0010, ch1=16'h0020, ch2=16'h0030, ch3=16'h0030 (duplicate, ch2 wins)
// Inputs are driven at the falling edge; outputs are sampled at the falling
// edge or 1 ns after an input change.
// -----------------------------------------------------------------------------
module tb_di_term_router;
    import di_router_pkg::*;

    localparam int                NT    = 4;
    localparam logic [NT*16-1:0]  ADDRS = {16'h0030, 16'h0030, 16'h0020, 16'h0010};

    logic ifclk = 1'b0;
    logic reset = 1'b1;
    always #5 ifclk = ~ifclk;

    di_term_router_if di_bus();

    logic [NT-1:0]    ch_read_mode, ch_read_req, ch_read, ch_write_mode, ch_write;
    logic [NT*16-1:0] ch_reg_datao, ch_transfer_status;
    logic [NT-1:0]    ch_read_rdy, ch_write_rdy;
    logic             busy;

    int total = 0;
    int bad   = 0;

    di_term_router #(
        .NUM_TERMS      (NT),
        .TERM_ADDRS     (ADDRS),
        .TIMEOUT_CYCLES (8),
        .UNDEF_DATA     (16'hAAAA)
    ) dut (
        .ifclk              (ifclk),
        .reset              (reset),
        .di                 (di_bus.slave),
        .ch_read_mode       (ch_read_mode),
        .ch_read_req        (ch_read_req),
        .ch_read            (ch_read),
        .ch_write_mode      (ch_write_mode),
        .ch_write           (ch_write),
        .ch_reg_datao       (ch_reg_datao),
        .ch_read_rdy        (ch_read_rdy),
        .ch_write_rdy       (ch_write_rdy),
        .ch_transfer_status (ch_transfer_status),
        .busy               (busy)
    );

    task automatic idle_inputs();
        di_bus.di_term_addr  = 16'h0000;
        di_bus.di_reg_addr   = 32'h0;
        di_bus.di_len        = 32'h0;
        di_bus.di_reg_datai  = 16'h0000;
        di_bus.di_read_mode  = 1'b0;
        di_bus.di_read_req   = 1'b0;
        di_bus.di_read       = 1'b0;
        di_bus.di_write_mode = 1'b0;
        di_bus.di_write      = 1'b0;
        ch_read_rdy          = 4'b1111;
        ch_write_rdy         = 4'b1111;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({ch_read_mode, ch_read_req, ch_read, ch_write_mode, ch_write} !== 20'h0) begin
            bad++; $display("FAIL reset_strobes: got %h want 00000", {ch_read_mode, ch_read_req, ch_read, ch_write_mode, ch_write}); end
        total++; if ({di_bus.di_read_rdy, di_bus.di_write_rdy} !== 2'b11) begin
            bad++; $display("FAIL reset_rdy: got %b want 11", {di_bus.di_read_rdy, di_bus.di_write_rdy}); end
        total++; if (di_bus.di_reg_datao !== 16'h0000) begin bad++; $display("FAIL reset_datao: got %h want 0000", di_bus.di_reg_datao); end
        total++; if (di_bus.di_transfer_status !== 16'h0000) begin bad++; $display("FAIL reset_status: got %h want 0000", di_bus.di_transfer_status); end
        reset = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_read_ch2();
        di_bus.di_term_addr = 16'h0030;
        di_bus.di_read_mode = 1'b1;
        ch_read_rdy         = 4'b0100;
        #1;
        total++; if (ch_read_mode !== 4'b0000) begin bad++; $display("FAIL rd_decode_latency: got %b want 0000", ch_read_mode); end
        @(negedge ifclk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy: got %b want 1", busy); end
        total++; if (ch_read_mode !== 4'b0100) begin bad++; $display("FAIL rd_mode_ch2: got %b want 0100", ch_read_mode); end
        di_bus.di_read_req = 1'b1;
        di_bus.di_read     = 1'b1;
        #1;
        total++; if (ch_read !== 4'b0100) begin bad++; $display("FAIL rd_strobe: got %b want 0100", ch_read); end
        total++; if (ch_read_req !== 4'b0100) begin bad++; $display("FAIL rd_req: got %b want 0100", ch_read_req); end
        total++; if (di_bus.di_reg_datao !== 16'h1234) begin bad++; $display("FAIL rd_data: got %h want 1234", di_bus.di_reg_datao); end
        total++; if (di_bus.di_read_rdy !== 1'b1) begin bad++; $display("FAIL rd_rdy: got %b want 1", di_bus.di_read_rdy); end
        total++; if (di_bus.di_transfer_status !== 16'h0A22) begin bad++; $display("FAIL rd_status: got %h want 0a22", di_bus.di_transfer_status); end
        total++; if ({ch_write_mode, ch_write} !== 8'h00) begin bad++; $display("FAIL rd_no_write: got %h want 00", {ch_write_mode, ch_write}); end
        @(negedge ifclk);
        di_bus.di_read     = 1'b0;
        di_bus.di_read_req = 1'b0;
        #1;
        total++; if (ch_read !== 4'b0000) begin bad++; $display("FAIL rd_strobe_low: got %b want 0000", ch_read); end
        di_bus.di_term_addr = 16'h0010;
        @(negedge ifclk);
        @(negedge ifclk);
        total++; if (di_bus.di_reg_datao !== 16'h1234) begin bad++; $display("FAIL rd_addr_change_data: got %h want 1234", di_bus.di_reg_datao); end
        total++; if (ch_read_mode !== 4'b0100) begin bad++; $display("FAIL rd_addr_change_sel: got %b want 0100", ch_read_mode); end
        ch_read_rdy = 4'b1011;
        #1;
        total++; if (di_bus.di_read_rdy !== 1'b0) begin bad++; $display("FAIL rd_rdy_mux: got %b want 0", di_bus.di_read_rdy); end
        @(negedge ifclk);
        di_bus.di_read_mode = 1'b0;
        #1;
        total++; if (ch_read_mode !== 4'b0000) begin bad++; $display("FAIL rd_mode_follow: got %b want 0000", ch_read_mode); end
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_exit_busy: got %b want 0", busy); end
        total++; if (di_bus.di_reg_datao !== 16'h0000) begin bad++; $display("FAIL rd_exit_data: got %h want 0000", di_bus.di_reg_datao); end
        idle_inputs();
    endtask

    task automatic test_unmapped_write();
        di_bus.di_term_addr  = 16'h00FF;
        di_bus.di_write_mode = 1'b1;
        ch_write_rdy         = 4'b0000;
        @(negedge ifclk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL um_busy: got %b want 1", busy); end
        di_bus.di_write = 1'b1;
        #1;
        total++; if ({ch_write_mode, ch_write} !== 8'h00) begin bad++; $display("FAIL um_no_strobe: got %h want 00", {ch_write_mode, ch_write}); end
        total++; if (di_bus.di_write_rdy !== 1'b1) begin bad++; $display("FAIL um_wr_rdy: got %b want 1", di_bus.di_write_rdy); end
        total++; if (di_bus.di_transfer_status !== 16'hFFFF) begin bad++; $display("FAIL um_status: got %h want ffff", di_bus.di_transfer_status); end
        total++; if (di_bus.di_reg_datao !== 16'hAAAA) begin bad++; $display("FAIL um_data: got %h want aaaa", di_bus.di_reg_datao); end
        @(negedge ifclk);
        di_bus.di_write      = 1'b0;
        di_bus.di_write_mode = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL um_exit_busy: got %b want 0", busy); end
        idle_inputs();
    endtask

    task automatic test_write_ch0();
        di_bus.di_term_addr  = 16'h0010;
        di_bus.di_write_mode = 1'b1;
        ch_write_rdy         = 4'b1110;
        @(negedge ifclk);
        di_bus.di_write = 1'b1;
        #1;
        total++; if (ch_write_mode !== 4'b0001) begin bad++; $display("FAIL wr_mode_ch0: got %b want 0001", ch_write_mode); end
        total++; if (ch_write !== 4'b0001) begin bad++; $display("FAIL wr_strobe: got %b want 0001", ch_write); end
        total++; if (di_bus.di_write_rdy !== 1'b0) begin bad++; $display("FAIL wr_rdy_low: got %b want 0", di_bus.di_write_rdy); end
        ch_write_rdy = 4'b0001;
        #1;
        total++; if (di_bus.di_write_rdy !== 1'b1) begin bad++; $display("FAIL wr_rdy_high: got %b want 1", di_bus.di_write_rdy); end
        total++; if (di_bus.di_transfer_status !== 16'h0A00) begin bad++; $display("FAIL wr_status: got %h want 0a00", di_bus.di_transfer_status); end
        @(negedge ifclk);
        di_bus.di_write      = 1'b0;
        di_bus.di_write_mode = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_exit_busy: got %b want 0", busy); end
        idle_inputs();
    endtask

    task automatic test_both_modes();
        di_bus.di_term_addr  = 16'h0020;
        di_bus.di_read_mode  = 1'b1;
        di_bus.di_write_mode = 1'b1;
        @(negedge ifclk);
        di_bus.di_read  = 1'b1;
        di_bus.di_write = 1'b1;
        #1;
        total++; if (ch_read_mode !== 4'b0010) begin bad++; $display("FAIL both_rd_mode: got %b want 0010", ch_read_mode); end
        total++; if ({ch_write_mode, ch_write} !== 8'h00) begin bad++; $display("FAIL both_no_write: got %h want 00", {ch_write_mode, ch_write}); end
        total++; if (ch_read !== 4'b0010) begin bad++; $display("FAIL both_rd_strobe: got %b want 0010", ch_read); end
        @(negedge ifclk);
        di_bus.di_write      = 1'b0;
        di_bus.di_write_mode = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL both_still_read: got %b want 1", busy); end
        di_bus.di_read      = 1'b0;
        di_bus.di_read_mode = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_exit_busy: got %b want 0", busy); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_write();
        di_bus.di_term_addr  = 16'h0020;
        di_bus.di_write_mode = 1'b1;
        @(negedge ifclk);
        di_bus.di_write = 1'b1;
        #1;
        total++; if (ch_write_mode !== 4'b0010) begin bad++; $display("FAIL rst_pre_mode: got %b want 0010", ch_write_mode); end
        #1;
        reset = 1'b1;
        #1;
        total++; if ({ch_write_mode, ch_write} !== 8'h00) begin bad++; $display("FAIL rst_async_strobes: got %h want 00", {ch_write_mode, ch_write}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        total++; if ({di_bus.di_read_rdy, di_bus.di_write_rdy} !== 2'b11) begin
            bad++; $display("FAIL rst_async_rdy: got %b want 11", {di_bus.di_read_rdy, di_bus.di_write_rdy}); end
        idle_inputs();
        @(negedge ifclk);
        reset = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy: got %b want 0", busy); end
    endtask

`ifdef DI_ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        di_bus.di_term_addr = 16'h0020;
        di_bus.di_read_mode = 1'b1;
        ch_read_rdy         = 4'b0000;
        @(negedge ifclk);
        di_bus.di_read_req = 1'b1;
        repeat (7) @(negedge ifclk);
        total++; if (di_bus.di_reg_datao !== 16'h1111) begin bad++; $display("FAIL to_before_limit: got %h want 1111", di_bus.di_reg_datao); end
        total++; if (di_bus.di_read_rdy !== 1'b0) begin bad++; $display("FAIL to_stall_rdy: got %b want 0", di_bus.di_read_rdy); end
        @(negedge ifclk);
        total++; if (di_bus.di_reg_datao !== 16'hDEAD) begin bad++; $display("FAIL to_abort_data: got %h want dead", di_bus.di_reg_datao); end
        total++; if (di_bus.di_transfer_status !== 16'hFFFE) begin bad++; $display("FAIL to_abort_status: got %h want fffe", di_bus.di_transfer_status); end
        total++; if ({di_bus.di_read_rdy, di_bus.di_write_rdy} !== 2'b11) begin
            bad++; $display("FAIL to_abort_rdy: got %b want 11", {di_bus.di_read_rdy, di_bus.di_write_rdy}); end
        total++; if ({ch_read_mode, ch_read_req} !== 8'h00) begin bad++; $display("FAIL to_abort_strobes: got %h want 00", {ch_read_mode, ch_read_req}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_abort_busy: got %b want 1", busy); end
        di_bus.di_read_req  = 1'b0;
        di_bus.di_read_mode = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_exit_busy: got %b want 0", busy); end
        idle_inputs();
    endtask
`else
    task automatic test_no_timeout();
        di_bus.di_term_addr = 16'h0020;
        di_bus.di_read_mode = 1'b1;
        ch_read_rdy         = 4'b0000;
        @(negedge ifclk);
        di_bus.di_read_req = 1'b1;
        repeat (20) @(negedge ifclk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL nto_busy: got %b want 1", busy); end
        total++; if (di_bus.di_reg_datao !== 16'h1111) begin bad++; $display("FAIL nto_data: got %h want 1111", di_bus.di_reg_datao); end
        total++; if (ch_read_req !== 4'b0010) begin bad++; $display("FAIL nto_req: got %b want 0010", ch_read_req); end
        di_bus.di_read_req  = 1'b0;
        di_bus.di_read_mode = 1'b0;
        @(negedge ifclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nto_exit_busy: got %b want 0", busy); end
        idle_inputs();
    endtask
`endif

    initial begin
        ch_reg_datao       = {16'h3333, 16'h1234, 16'h1111, 16'h1000};
        ch_transfer_status = {16'h0A33, 16'h0A22, 16'h0A11, 16'h0A00};
        test_reset();
        test_read_ch2();
        test_unmapped_write();
        test_write_ch0();
        test_both_modes();
        test_reset_mid_write();
`ifdef DI_ROUTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/di_term_router.md
# di_term_router

Parametrised device-interface terminal router that replaces the hand-written per-terminal `if/else` mux in the project top level. It sits between the FX2 device-interface (`di_*`) port and up to `NUM_TERMS` terminal blocks. For the duration of a transfer it latches the addressed terminal, gates strobes to that terminal only, and muxes its read data, ready flags and status back. A per-transfer watchdog aborts transfers whose terminal stalls, so the host never hangs.

## Interface
Parameters:
- `NUM_TERMS`, 4: number of attached terminals (1–16).
- `TERM_ADDRS`, {16'h0003,16'h0002,16'h0001,16'h0000}: flattened `NUM_TERMS*16` list; channel i address = bits [16i+15:16i].
- `TIMEOUT_CYCLES`, 4096: stall limit in clocks (2..65535).
- `UNDEF_DATA`, 16'hAAAA: read data for an unmapped terminal.

Ports:
- `ifclk` in 1: 48 MHz interface clock, sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `di_term_addr` in 16; `di_reg_addr` in 32; `di_len` in 32; `di_reg_datai` in 16: host side, broadcast to all channels.
- `di_read_mode`, `di_read_req`, `di_read`, `di_write_mode`, `di_write` in 1 each: host strobes.
- `di_reg_datao` out 16; `di_read_rdy` out 1; `di_write_rdy` out 1; `di_transfer_status` out 16: host returns.
- `ch_read_mode`, `ch_read_req`, `ch_read`, `ch_write_mode`, `ch_write` out `NUM_TERMS`: gated strobes, one bit per channel.
- `ch_reg_datao` in `NUM_TERMS*16`; `ch_read_rdy`, `ch_write_rdy` in `NUM_TERMS`; `ch_transfer_status` in `NUM_TERMS*16`: per-channel returns.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, READ, WRITE, ABORT, UNMAPPED.
- IDLE: a rising `di_read_mode` (or `di_write_mode`) decodes `di_term_addr` against `TERM_ADDRS`; lowest matching index wins. Index latched into `sel`. Next state is READ/WRITE on a hit, UNMAPPED on a miss. If both modes rise in the same cycle, read wins.
- READ/WRITE: `ch_*_mode[sel]` follows `di_*_mode`; `ch_read_req/ch_read/ch_write[sel]` = host strobe; all other channel bits are 0. Returns are muxed from `sel`.
- UNMAPPED: `di_reg_datao`=`UNDEF_DATA`, both rdy=1, status=16'hFFFF. No channel strobes.
- Exit: when the active mode falls, go to IDLE on the next edge. A mode change mid-transfer (opposite mode rising) is ignored until IDLE.
- IDLE outputs: `di_reg_datao`=0, rdy=1, status=0.

## Timing
- `sel` and state registered; returns are a combinational mux of registered `sel`, giving zero added latency on data/rdy.
- Channel strobes begin the cycle after the mode rising edge (1-cycle decode). The host does not strobe in the first mode cycle, which is existing FX2 behaviour.
- Reset values: state IDLE, `sel`=0, counter 0, all `ch_*` 0, `busy` 0, `di_read_rdy`=`di_write_rdy`=1, `di_reg_datao`=0, status 0.
- Reset asserted mid-transfer drops all channel strobes asynchronously.

## Configuration
- `DI_ROUTER_TIMEOUT_EN` defined: watchdog compiled in.
  - A 16-bit counter clears on every cycle where the selected rdy is high or no request/strobe is pending. Otherwise it increments and saturates.
  - At count == `TIMEOUT_CYCLES`, go to ABORT. ABORT drives rdy=1, datao=16'hDEAD, status=16'hFFFE, and channel strobes 0, until the mode falls.
- Undefined: no counter, no ABORT state. READ/WRITE wait indefinitely.

## Structure
- Shared package `di_router_pkg`: state encoding, `DI_STATUS_UNDEF`=16'hFFFF, `DI_STATUS_TIMEOUT`=16'hFFFE, `DI_ABORT_DATA`=16'hDEAD.
- One sub-module, `di_addr_decode`: combinational priority match of an address to {hit, index}. It is reused by future register terminals.

## Test plan
- Read from `TERM_ADDRS` channel 2 with `ch_read_rdy[2]`=1 and data 16'h1234 -> `di_reg_datao`=16'h1234; `ch_read[2]` mirrors `di_read`; `ch_read` bits 0,1,3 stay 0.
- Write to an unmapped address 16'h00FF -> UNMAPPED state, `di_write_rdy`=1, status 16'hFFFF, all `ch_write`=0.
- `di_term_addr` changes during an active read -> `sel` unchanged and data still from the original channel until the mode falls.
- Timeout enabled, `TIMEOUT_CYCLES`=8, channel 1 holds `ch_read_rdy`=0 with `di_read_req` high -> ABORT on cycle 8, datao 16'hDEAD, status 16'hFFFE; return to IDLE after the mode falls.
- `reset` pulsed for 1 cycle mid-write -> all `ch_write_mode` 0 immediately, `busy` 0, rdy outputs 1.
- Read and write modes rise in the same cycle -> READ state entered; write strobes not forwarded.
